// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcode classes,
// opcode class boundaries, pc_src/wb_data selects and branch-condition modes.
// Macro CTRL_PERF_CNT_EN (used by the top) adds cycle/instruction counters.
package ctrl_pkg;

  // FSM state encodings (3-bit, visible on state_o)
  localparam logic [2:0] ST_IF   = 3'b000;
  localparam logic [2:0] ST_ID   = 3'b001;
  localparam logic [2:0] ST_EX   = 3'b010;
  localparam logic [2:0] ST_MEM  = 3'b011;
  localparam logic [2:0] ST_WB   = 3'b100;
  localparam logic [2:0] ST_TRAP = 3'b111;

  typedef enum logic [3:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_STK_WR,
    CLS_STK_RD,
    CLS_ILLEGAL
  } op_class_t;

  // Upper bound of each contiguous opcode class (classes are laid out in order)
  localparam logic [5:0] OP_ALU_R_HI  = 6'h02;
  localparam logic [5:0] OP_ALU_I_HI  = 6'h04;
  localparam logic [5:0] OP_LOAD_HI   = 6'h06;
  localparam logic [5:0] OP_STORE     = 6'h07;
  localparam logic [5:0] OP_BRANCH_HI = 6'h0B;
  localparam logic [5:0] OP_JUMP      = 6'h0C;
  localparam logic [5:0] OP_STK_WR_HI = 6'h0F;
  localparam logic [5:0] OP_STK_RD    = 6'h10;

  localparam logic [1:0] PC_SRC_INC = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_STK = 2'b10;

  localparam logic [1:0] MODE_Z  = 2'b00;
  localparam logic [1:0] MODE_NZ = 2'b01;
  localparam logic [1:0] MODE_N  = 2'b10;
  localparam logic [1:0] MODE_C  = 2'b11;

  // Branch condition evaluation from the mode select and ALU flags
  function automatic logic branch_taken(input logic [1:0] mode, input logic z,
                                        input logic c, input logic n);
    logic t;
    case (mode)
      MODE_Z:  t = z;
      MODE_NZ: t = !z;
      MODE_N:  t = n;
      default: t = c;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: maps an opcode to its class and flags illegal ones.
// Zero latency, no state. Opcodes with any bit set above bit 5 are illegal.
module ctrl_opcode_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class,
  output logic                illegal
);

  logic [5:0] low;
  logic       upper_set;

  assign low = opcode[5:0];

  if (OPCODE_W > 6) begin : g_upper
    assign upper_set = |opcode[OPCODE_W-1:6];
  end else begin : g_no_upper
    assign upper_set = 1'b0;
  end

  // Range decode; classes occupy ascending contiguous opcode ranges
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (!upper_set) begin
      if (low <= OP_ALU_R_HI)       op_class = CLS_ALU_R;
      else if (low <= OP_ALU_I_HI)  op_class = CLS_ALU_I;
      else if (low <= OP_LOAD_HI)   op_class = CLS_LOAD;
      else if (low == OP_STORE)     op_class = CLS_STORE;
      else if (low <= OP_BRANCH_HI) op_class = CLS_BRANCH;
      else if (low == OP_JUMP)      op_class = CLS_JUMP;
      else if (low <= OP_STK_WR_HI) op_class = CLS_STK_WR;
      else if (low == OP_STK_RD)    op_class = CLS_STK_RD;
      else                          op_class = CLS_ILLEGAL;
    end
  end

  assign illegal = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB/TRAP) with memory wait states and timeout trap.
// Outputs are combinational from state, latched opcode, flags and mem_ready; all forced 0 in reset.
// Optional CTRL_PERF_CNT_EN adds saturating 32-bit cycle_cnt / instr_cnt outputs.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                carry_flag,
  input  logic                neg_flag,
  input  logic [1:0]          mode,
  input  logic                mem_ready,
  output logic [1:0]          pc_src,
  output logic                ext_src,
  output logic                reg_w1,
  output logic                reg_w2,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                reg_des,
  output logic                alu_src,
  output logic [1:0]          wb_data,
  output logic                j_src,
  output logic                pc_we,
  output logic [2:0]          state_o,
  output logic                retire,
`ifdef CTRL_PERF_CNT_EN
  output logic                trap,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`else
  output logic                trap
`endif
);

  localparam logic [TO_CNT_W-1:0] TO_LIM = TO_CNT_W'(MEM_TIMEOUT);
  localparam bit                  TO_EN  = (MEM_TIMEOUT != 0);

  logic [2:0]          state, nxt;
  logic [OPCODE_W-1:0] op_q, dec_op;
  logic [TO_CNT_W-1:0] wait_cnt;
  op_class_t           cls;
  logic                illegal, waiting, timeout;
  logic [1:0]          pc_src_raw, wb_data_raw;
  logic                ext_src_raw, reg_w1_raw, reg_w2_raw, mem_rd_raw, mem_wr_raw;
  logic                reg_des_raw, alu_src_raw, pc_we_raw, retire_raw;

  // ID decides on the live opcode; later states use the copy latched in ID
  assign dec_op = (state == ST_ID) ? opcode : op_q;

  ctrl_opcode_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (dec_op),
    .op_class (cls),
    .illegal  (illegal)
  );

  assign waiting = ((state == ST_IF) || (state == ST_MEM)) && !mem_ready;
  assign timeout = TO_EN && (wait_cnt == TO_LIM) && !mem_ready;

  // Next-state selection and per-state control decode
  always_comb begin
    nxt         = state;
    pc_src_raw  = PC_SRC_INC;
    wb_data_raw = WB_ALU;
    ext_src_raw = 1'b0;
    reg_w1_raw  = 1'b0;
    reg_w2_raw  = 1'b0;
    mem_rd_raw  = 1'b0;
    mem_wr_raw  = 1'b0;
    reg_des_raw = 1'b0;
    alu_src_raw = 1'b0;
    pc_we_raw   = 1'b0;
    retire_raw  = 1'b0;
    case (state)
      ST_IF: begin
        mem_rd_raw = 1'b1;
        if (mem_ready)    nxt = ST_ID;
        else if (timeout) nxt = ST_TRAP;
      end
      ST_ID: begin
        if (illegal) begin
          nxt = ST_TRAP;
        end else if (cls == CLS_JUMP) begin
          pc_src_raw = PC_SRC_JMP;
          pc_we_raw  = 1'b1;
          retire_raw = 1'b1;
          nxt        = ST_IF;
        end else begin
          nxt = ST_EX;
        end
      end
      ST_EX: begin
        case (cls)
          CLS_ALU_R: nxt = ST_WB;
          CLS_ALU_I: begin
            alu_src_raw = 1'b1;
            ext_src_raw = 1'b1;
            nxt         = ST_WB;
          end
          CLS_LOAD, CLS_STORE, CLS_STK_WR, CLS_STK_RD: begin
            alu_src_raw = 1'b1;
            ext_src_raw = 1'b1;
            nxt         = ST_MEM;
          end
          CLS_BRANCH: begin
            // Not-taken branches still advance the PC (PC+1) as their final step
            if (branch_taken(mode, zero_flag, carry_flag, neg_flag)) pc_src_raw = PC_SRC_BR;
            pc_we_raw  = 1'b1;
            retire_raw = 1'b1;
            nxt        = ST_IF;
          end
          default: nxt = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_rd_raw = (cls == CLS_LOAD) || (cls == CLS_STK_RD);
        mem_wr_raw = (cls == CLS_STORE) || (cls == CLS_STK_WR);
        if (mem_ready) begin
          if (mem_rd_raw) begin
            nxt = ST_WB;
          end else begin
            pc_we_raw  = 1'b1;
            retire_raw = 1'b1;
            nxt        = ST_IF;
          end
        end else if (timeout) begin
          nxt = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_w1_raw  = 1'b1;
        reg_w2_raw  = (cls == CLS_STK_WR) || (cls == CLS_STK_RD);
        reg_des_raw = (cls == CLS_ALU_I) || (cls == CLS_LOAD);
        if (cls == CLS_LOAD)        wb_data_raw = WB_MEM;
        else if (cls == CLS_STK_RD) wb_data_raw = WB_STK;
        pc_we_raw  = 1'b1;
        retire_raw = 1'b1;
        nxt        = ST_IF;
      end
      ST_TRAP: nxt = ST_TRAP;
      default: nxt = ST_TRAP;
    endcase
  end

  // State, latched opcode and wait counter (counter restarts on every state change)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IF;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == ST_ID) op_q <= opcode;
      if (nxt != state)  wait_cnt <= '0;
      else if (waiting)  wait_cnt <= wait_cnt + TO_CNT_W'(1);
    end
  end

  // Every output is held low while reset is asserted, aborting any access in flight
  assign pc_src  = rst_n ? pc_src_raw  : 2'b00;
  assign wb_data = rst_n ? wb_data_raw : 2'b00;
  assign ext_src = rst_n && ext_src_raw;
  assign reg_w1  = rst_n && reg_w1_raw;
  assign reg_w2  = rst_n && reg_w2_raw;
  assign mem_rd  = rst_n && mem_rd_raw;
  assign mem_wr  = rst_n && mem_wr_raw;
  assign reg_des = rst_n && reg_des_raw;
  assign alu_src = rst_n && alu_src_raw;
  assign pc_we   = rst_n && pc_we_raw;
  assign retire  = rst_n && retire_raw;
  assign j_src   = 1'b0;  // the only jump class takes its target from the immediate
  assign state_o = rst_n ? state : 3'b000;
  assign trap    = rst_n && (state == ST_TRAP);

`ifdef CTRL_PERF_CNT_EN
  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if ((state != ST_TRAP) && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire_raw && (instr_cnt != '1))         instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: directed instruction scenarios then random ones.
// Expected per-cycle output vectors come from a transaction-level model of each instruction.
// Non-EX cycles get random flags/opcode/mode to show those inputs are ignored there.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, zero_flag, carry_flag, neg_flag, mem_ready;
  logic [5:0] opcode;
  logic [1:0] mode, pc_src, wb_data;
  logic       ext_src, reg_w1, reg_w2, mem_rd, mem_wr, reg_des, alu_src, j_src, pc_we, retire, trap;
  logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  multicycle_ctrl_fsm #(.OPCODE_W(6), .MEM_TIMEOUT(TO), .TO_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .neg_flag(neg_flag), .mode(mode), .mem_ready(mem_ready), .pc_src(pc_src), .ext_src(ext_src),
    .reg_w1(reg_w1), .reg_w2(reg_w2), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_des(reg_des),
    .alu_src(alu_src), .wb_data(wb_data), .j_src(j_src), .pc_we(pc_we), .state_o(state_o),
    .retire(retire),
`ifdef CTRL_PERF_CNT_EN
    .trap(trap), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`else
    .trap(trap)
`endif
  );

  // Observed vector: {state(3), pc_src(2), ext, w1, w2, rd, wr, des, alu_src, wb(2), j_src, pc_we, retire, trap}
  logic [17:0] obs;
  assign obs = {state_o, pc_src, ext_src, reg_w1, reg_w2, mem_rd, mem_wr, reg_des, alu_src,
                wb_data, j_src, pc_we, retire, trap};

  localparam logic [17:0] S_IF = 18'h00000, S_ID = 18'h08000, S_EX = 18'h10000,
                          S_MEM = 18'h18000, S_WB = 18'h20000, S_TRAP = 18'h38000;
  localparam logic [17:0] PCS_BR = 18'h02000, PCS_JMP = 18'h04000;
  localparam logic [17:0] M_EXT = 18'h01000, M_W1 = 18'h00800, M_W2 = 18'h00400,
                          M_RD = 18'h00200, M_WR = 18'h00100, M_DES = 18'h00080,
                          M_ALS = 18'h00040, WB_MEMV = 18'h00010, WB_STKV = 18'h00020,
                          M_PCWE = 18'h00004, M_RET = 18'h00002, M_TRAP = 18'h00001;

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;
  int exp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock: drive inputs after the falling edge, compare outputs before the rising edge
  task automatic cyc(input string tag, input bit rst, input bit mr, input logic [5:0] op,
                     input bit z, input bit c, input bit n, input logic [1:0] md,
                     input logic [17:0] exp);
    @(negedge clk);
    rst_n = rst; mem_ready = mr; opcode = op;
    zero_flag = z; carry_flag = c; neg_flag = n; mode = md;
    #1;
    chk(tag, 32'(obs), 32'(exp));
    if (!rst) begin
      exp_ret = 0;
      exp_cyc = 0;
    end else begin
      if (exp[1]) exp_ret++;
      if (exp[17:15] != 3'b111) exp_cyc++;
    end
  endtask

  // Cycle whose opcode/flags/mode must not matter
  task automatic cycr(input string tag, input bit rst, input bit mr, input logic [17:0] exp);
    cyc(tag, rst, mr, 6'($urandom), rb(), rb(), rb(), 2'($urandom), exp);
  endtask

  task automatic trap_then_reset();
    for (int k = 0; k < 3; k++) cycr("trap_hold", 1'b1, rb(), S_TRAP | M_TRAP);
    cycr("reset_cycle", 1'b0, rb(), 18'h0);
  endtask

  // 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 STK_WR, 7 STK_RD, 8 illegal
  function automatic int class_of(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v <= 2)  return 0;
    if (v <= 4)  return 1;
    if (v <= 6)  return 2;
    if (v == 7)  return 3;
    if (v <= 11) return 4;
    if (v == 12) return 5;
    if (v <= 15) return 6;
    if (v == 16) return 7;
    return 8;
  endfunction

  // Walk one instruction through the machine, checking every cycle against the model
  task automatic run_instr(input logic [5:0] op, input int if_w, input int mem_w,
                           input bit z, input bit c, input bit n, input logic [1:0] md,
                           input bit abort);
    int cls;
    bit taken, rd_cls;
    logic [17:0] e;
    cls = class_of(op);
    for (int i = 0; i < if_w; i++) begin
      cycr("if_wait", 1'b1, 1'b0, S_IF | M_RD);
      if (i == TO) begin
        trap_then_reset();
        return;
      end
    end
    cycr("if_ready", 1'b1, 1'b1, S_IF | M_RD);
    if (cls == 5) begin
      cyc("id_jump", 1'b1, rb(), op, rb(), rb(), rb(), 2'($urandom), S_ID | PCS_JMP | M_PCWE | M_RET);
      return;
    end
    cyc("id", 1'b1, rb(), op, rb(), rb(), rb(), 2'($urandom), S_ID);
    if (cls == 8) begin
      trap_then_reset();
      return;
    end
    if (cls == 4) begin
      case (md)
        2'd0: taken = z;
        2'd1: taken = !z;
        2'd2: taken = n;
        default: taken = c;
      endcase
      e = S_EX | M_PCWE | M_RET | (taken ? PCS_BR : 18'h0);
      cyc("ex_branch", 1'b1, rb(), 6'($urandom), z, c, n, md, e);
      return;
    end
    e = S_EX | ((cls == 0) ? 18'h0 : (M_ALS | M_EXT));
    cycr("ex", 1'b1, rb(), e);
    if (cls >= 2 && cls != 4) begin
      if (cls == 0 || cls == 1) begin
        // ALU classes go straight to write-back
      end else begin
        rd_cls = (cls == 2) || (cls == 7);
        e = S_MEM | (rd_cls ? M_RD : M_WR);
        for (int i = 0; i < mem_w; i++) begin
          cycr("mem_wait", 1'b1, 1'b0, e);
          if (i == TO) begin
            trap_then_reset();
            return;
          end
        end
        if (abort) begin
          cycr("abort_reset", 1'b0, rb(), 18'h0);
          return;
        end
        if (!rd_cls) begin
          cycr("mem_store_done", 1'b1, 1'b1, e | M_PCWE | M_RET);
          return;
        end
        cycr("mem_load_done", 1'b1, 1'b1, e);
      end
    end
    e = S_WB | M_W1 | M_PCWE | M_RET;
    if (cls == 1) e |= M_DES;
    if (cls == 2) e |= M_DES | WB_MEMV;
    if (cls == 7) e |= M_W2 | WB_STKV;
    cycr("wb", 1'b1, rb(), e);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 3);
    if (r == 17) return TO;
    if (r == 18) return TO + 1;
    return TO + 4;
  endfunction

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0;
    zero_flag = 1'b0; carry_flag = 1'b0; neg_flag = 1'b0; mode = 2'b00;
    cycr("reset_outputs", 1'b0, 1'b1, 18'h0);
    cycr("reset_outputs", 1'b0, 1'b0, 18'h0);

    // Directed scenarios
    run_instr(6'h01, 0, 0, 0, 0, 0, 2'b00, 0);   // ALU_R, 4 cycles
    run_instr(6'h05, 0, 3, 0, 0, 0, 2'b00, 0);   // LOAD, 3 memory wait states
    run_instr(6'h09, 0, 0, 0, 0, 0, 2'b01, 0);   // !Z branch taken
    run_instr(6'h09, 0, 0, 1, 0, 0, 2'b01, 0);   // !Z branch not taken
    run_instr(6'h0A, 0, 0, 0, 0, 1, 2'b10, 0);   // N branch taken
    run_instr(6'h0B, 0, 0, 0, 0, 0, 2'b11, 0);   // C branch not taken
    run_instr(6'h0C, 0, 0, 0, 0, 0, 2'b00, 0);   // jump from ID
    run_instr(6'h3F, 0, 0, 0, 0, 0, 2'b00, 0);   // illegal, trap then reset
    run_instr(6'h11, 0, 0, 0, 0, 0, 2'b00, 0);   // first illegal above STK_RD
    run_instr(6'h03, 0, 0, 0, 0, 0, 2'b00, 0);   // ALU_I
    run_instr(6'h07, 1, 2, 0, 0, 0, 2'b00, 0);   // STORE
    run_instr(6'h0E, 0, 1, 0, 0, 0, 2'b00, 0);   // STK_WR
    run_instr(6'h10, 2, 0, 0, 0, 0, 2'b00, 0);   // STK_RD
    run_instr(6'h01, TO + 1, 0, 0, 0, 0, 2'b00, 0); // fetch timeout on wait cycle 16
    run_instr(6'h01, TO, 0, 0, 0, 0, 2'b00, 0);     // ready on cycle 16 wins
    run_instr(6'h06, 0, TO + 1, 0, 0, 0, 2'b00, 0); // memory-stage timeout
    run_instr(6'h06, 0, TO, 0, 0, 0, 2'b00, 0);     // memory ready just in time
    run_instr(6'h05, 1, 2, 0, 0, 0, 2'b00, 1);      // reset mid memory wait

    // Random instruction stream
    for (int t = 0; t < 250; t++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(17, 63));
      else                           op = 6'($urandom_range(0, 16));
      run_instr(op, pick_wait(), pick_wait(), rb(), rb(), rb(), 2'($urandom),
                ($urandom_range(0, 19) == 0));
    end

`ifdef CTRL_PERF_CNT_EN
    @(negedge clk);
    #1;
    chk("instr_cnt", instr_cnt, 32'(exp_ret));
    chk("cycle_cnt", cycle_cnt, 32'(exp_cyc));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
